instr_fetch: RTL and testbench

- Single-issue instruction fetch stage that sits directly upstream of MainDecoder.
- Holds the PC and requests instructions from instruction memory over a request/response handshake.
- Latches each returned word and presents it, with its opcode field as OpCode_t, to decode/execute under a valid/ready handshake.
- Applies the next-PC redirect (branch/jump) when the current instruction is consumed.

---
 rtl/Opcode_pkg.sv | 35 +++
 rtl/instr_fetch_program_counter.sv | 59 +++++
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/Opcode_pkg.sv
// Shared opcode and fetch-stage definitions for the front end.
//   OpCode_t         : RV32 major opcodes seen by MainDecoder (instr[6:0]).
//   FetchState_t     : instr_fetch FSM states.
//   RESET_PC_DEFAULT : default PC after reset.
//   is_misaligned    : true when a 32-bit instruction address is not word aligned.
package Opcode_pkg;

  localparam int unsigned OPCODE_W         = 7;
  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [OPCODE_W-1:0] {
    OPC_LOAD   = 7'b000_0011,
    OPC_OP_IMM = 7'b001_0011,
    OPC_AUIPC  = 7'b001_0111,
    OPC_STORE  = 7'b010_0011,
    OPC_OP     = 7'b011_0011,
    OPC_LUI    = 7'b011_0111,
    OPC_BRANCH = 7'b110_0011,
    OPC_JALR   = 7'b110_0111,
    OPC_JAL    = 7'b110_1111,
    OPC_SYSTEM = 7'b111_0011
  } OpCode_t;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } FetchState_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_program_counter.sv
// Program counter for instr_fetch: PC register, +4 adder, next-PC mux and
// redirect alignment check.
//   i_Clk, i_Reset   : clock, synchronous active-high reset
//   i_Advance        : current instruction consumed; load next PC
//   i_PCSrc          : 1 = take i_PCTarget (forced word aligned), 0 = PC + 4
//   i_PCTarget       : redirect target
//   o_PC, o_PCPlus4  : registered PC and PC + 4 (modulo 2^XLEN)
//   o_Misalign_c     : combinational pulse, redirect taken to a misaligned target
module program_counter
  import Opcode_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_Advance,
  input  logic            i_PCSrc,
  input  logic [XLEN-1:0] i_PCTarget,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_PCPlus4,
  output logic            o_Misalign_c
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  // Next-PC select; PC + 4 is kept registered so it is ready as a sequential target.
  always_comb begin
    pc_d         = pc_q;
    pc_plus4_d   = pc_plus4_q;
    o_Misalign_c = 1'b0;
    if (i_Advance) begin
      if (i_PCSrc) begin
        pc_d         = {i_PCTarget[XLEN-1:2], 2'b00};
        o_Misalign_c = is_misaligned(i_PCTarget[1:0]);
      end else begin
        pc_d = pc_plus4_q;
      end
      pc_plus4_d = pc_d + PC_STEP;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + PC_STEP;
    end else begin
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign o_PC      = pc_q;
  assign o_PCPlus4 = pc_plus4_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch stage feeding MainDecoder.
//   Memory side : o_IMemReq/o_IMemAddr/i_IMemReady request, i_IMemRValid/i_IMemRData response
//   Decode side : o_InstrValid/i_InstrReady handshake carrying o_Instr, o_OpCode, o_PC, o_PCPlus4
//   Redirect    : i_PCSrc/i_PCTarget sampled only when an instruction is consumed
//   Status      : o_MisalignErr, sticky until reset
// o_OpCode is a combinational view of o_Instr[6:0]; all other outputs come from flops.
module instr_fetch
  import Opcode_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  output logic            o_IMemReq,
  output logic [XLEN-1:0] o_IMemAddr,
  input  logic            i_IMemReady,
  input  logic            i_IMemRValid,
  input  logic [XLEN-1:0] i_IMemRData,
  output logic            o_InstrValid,
  input  logic            i_InstrReady,
  output logic [XLEN-1:0] o_Instr,
  output OpCode_t         o_OpCode,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_PCPlus4,
  input  logic            i_PCSrc,
  input  logic [XLEN-1:0] i_PCTarget,
  output logic            o_MisalignErr
);

  FetchState_t     state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            misalign_err_q, misalign_err_d;
  logic            drop_q, drop_d;
  logic            drop_rst_c;
  logic            advance_c;
  logic            pc_misalign_c;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  assign advance_c = (state_q == VALID) && i_InstrReady;

  program_counter #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Advance    (advance_c),
    .i_PCSrc      (i_PCSrc),
    .i_PCTarget   (i_PCTarget),
    .o_PC         (pc),
    .o_PCPlus4    (pc_plus4),
    .o_Misalign_c (pc_misalign_c)
  );

  // A reset during WAIT leaves one response in flight; remember to swallow it,
  // unless it lands in the reset cycle itself.
  assign drop_rst_c = ((state_q == WAIT) || drop_q) && !i_IMemRValid;

  // Fetch FSM, instruction register and stale-response drop flag.
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    drop_d         = drop_q;
    misalign_err_d = misalign_err_q || pc_misalign_c;

    case (state_q)
      REQ: begin
        if (i_IMemReady) begin
          // Request accepted: any stale response is now behind us (in-order memory).
          drop_d = 1'b0;
          if (i_IMemRValid && !drop_q) begin
            instr_d = i_IMemRData;
            state_d = VALID;
          end else begin
            state_d = WAIT;
          end
        end else if (i_IMemRValid && drop_q) begin
          drop_d = 1'b0;
        end
      end
      WAIT: begin
        if (i_IMemRValid) begin
          instr_d = i_IMemRData;
          state_d = VALID;
        end
      end
      VALID: begin
        if (i_InstrReady) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    req_d   = (state_d == REQ);
    valid_d = (state_d == VALID);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q        <= REQ;
      instr_q        <= '0;
      req_q          <= 1'b1;
      valid_q        <= 1'b0;
      misalign_err_q <= 1'b0;
      drop_q         <= drop_rst_c;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      req_q          <= req_d;
      valid_q        <= valid_d;
      misalign_err_q <= misalign_err_d;
      drop_q         <= drop_d;
    end
  end

  // A response is only legal while a request is being accepted, in WAIT,
  // or as the stale response being dropped.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      assert (!(i_IMemRValid &&
                (((state_q == REQ) && !i_IMemReady && !drop_q) || (state_q == VALID))))
        else $error("instr_fetch: i_IMemRValid outside an outstanding request");
    end
  end

  assign o_IMemReq     = req_q;
  assign o_IMemAddr    = pc;
  assign o_InstrValid  = valid_q;
  assign o_Instr       = instr_q;
  assign o_OpCode      = OpCode_t'(instr_q[6:0]);
  assign o_PC          = pc;
  assign o_PCPlus4     = pc_plus4;
  assign o_MisalignErr = misalign_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes the expected instruction,
// PC and opcode when it issues a fetch; a monitor pops and compares when
// o_InstrValid rises and checks the outputs stay stable while held.
module tb_instr_fetch;
  import Opcode_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  OpCode_t     opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        misalign_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  instr_fetch #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .o_IMemReq     (imem_req),
    .o_IMemAddr    (imem_addr),
    .i_IMemReady   (imem_ready),
    .i_IMemRValid  (imem_rvalid),
    .i_IMemRData   (imem_rdata),
    .o_InstrValid  (instr_valid),
    .i_InstrReady  (instr_ready),
    .o_Instr       (instr),
    .o_OpCode      (opcode),
    .o_PC          (pc),
    .o_PCPlus4     (pc_plus4),
    .i_PCSrc       (pc_src),
    .i_PCTarget    (pc_target),
    .o_MisalignErr (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on each new valid instruction, then check it is held stable.
  initial begin : monitor
    exp_t cur;
    logic prev_valid;
    cur        = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got instr %h pc %h expected no instruction", instr, pc);
          end else begin
            cur = exp_q.pop_front();
            chk32("sb_instr", instr, cur.instr);
            chk32("sb_pc", pc, cur.pc);
            chk32("sb_pcplus4", pc_plus4, cur.pc + 32'd4);
            chk32("sb_opcode", 32'(opcode), 32'(cur.opc));
          end
        end else begin
          chk32("hold_instr", instr, cur.instr);
          chk32("hold_pc", pc, cur.pc);
        end
        chk1("valid_noreq", imem_req, 1'b0);
      end
      prev_valid = instr_valid && !rst;
    end
  end

  // All stimulus and direct checks happen at the falling edge.
  // Entry: DUT in REQ. Exit: at the first cycle with o_InstrValid high.
  task automatic fetch(input logic [31:0] addr, input int rdelay, input int k,
                       input logic [31:0] word, input logic [6:0] opc);
    exp_t e;
    for (int i = 0; i < rdelay; i++) begin
      chk1("req_hold", imem_req, 1'b1);
      chk32("addr_hold", imem_addr, addr);
      imem_ready = 1'b0;
      @(negedge clk);
    end
    chk1("req", imem_req, 1'b1);
    chk32("addr", imem_addr, addr);
    imem_ready  = 1'b1;
    imem_rvalid = (k == 0);
    imem_rdata  = (k == 0) ? word : 32'h0;
    e.instr = word;
    e.pc    = addr;
    e.opc   = opc;
    exp_q.push_back(e);
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    if (k > 0) begin
      for (int i = 0; i < k - 1; i++) begin
        chk1("wait_noreq", imem_req, 1'b0);
        chk1("wait_novalid", instr_valid, 1'b0);
        @(negedge clk);
      end
      chk1("rsp_novalid", instr_valid, 1'b0);
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      @(negedge clk);
      imem_rvalid = 1'b0;
    end
    chk1("latency_valid", instr_valid, 1'b1);
  endtask

  // Hold for 'hold' cycles (with a junk redirect that must be ignored), then consume.
  task automatic consume(input int hold, input logic src, input logic [31:0] target,
                         input logic [31:0] next_addr);
    for (int i = 0; i < hold; i++) begin
      chk1("stall_valid", instr_valid, 1'b1);
      instr_ready = 1'b0;
      pc_src      = 1'b1;
      pc_target   = 32'h0000_BAD0;
      @(negedge clk);
    end
    chk1("consume_valid", instr_valid, 1'b1);
    instr_ready = 1'b1;
    pc_src      = src;
    pc_target   = target;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'h0;
    chk1("valid_drop", instr_valid, 1'b0);
    chk1("next_req", imem_req, 1'b1);
    chk32("next_addr", imem_addr, next_addr);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "tb_instr_fetch timeout");
  end

  initial begin : stimulus
    rst         = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'h0;
    repeat (2) @(negedge clk);
    chk1("rst_valid", instr_valid, 1'b0);
    chk32("rst_instr", instr, 32'h0);
    chk1("rst_misalign", misalign_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("first_req", imem_req, 1'b1);
    chk32("first_addr", imem_addr, 32'h0);

    // Zero-latency addi at PC 0.
    fetch(32'h0, 0, 0, 32'h0050_0093, 7'h13);
    consume(0, 1'b0, 32'h0, 32'h4);

    // Ready low 2 cycles, 3-cycle response; jal stalled 5 cycles then redirect to 0x40.
    fetch(32'h4, 2, 3, 32'h0000_006F, 7'h6F);
    consume(5, 1'b1, 32'h0000_0040, 32'h0000_0040);

    // Misaligned redirect 0x42 -> 0x40, sticky error.
    fetch(32'h40, 0, 1, 32'h0000_0013, 7'h13);
    consume(0, 1'b1, 32'h0000_0042, 32'h0000_0040);
    chk1("misalign_set", misalign_err, 1'b1);

    // Ten more fetches; the last redirects to the top word of the address space.
    for (int i = 0; i < 10; i++) begin
      fetch(32'h40 + 32'(4 * i), i % 3, i % 2, 32'h0000_0033 | 32'(i << 7), 7'h33);
      consume(0, (i == 9), 32'hFFFF_FFFC,
              (i == 9) ? 32'hFFFF_FFFC : 32'h44 + 32'(4 * i));
      chk1("misalign_sticky", misalign_err, 1'b1);
    end

    // PC + 4 wraps to 0.
    fetch(32'hFFFF_FFFC, 0, 0, 32'h0000_0063, 7'h63);
    consume(0, 1'b0, 32'h0, 32'h0);

    // Reset while waiting; stale word arrives one cycle after reset deasserts.
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk1("wait_state_noreq", imem_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("rst2_valid", instr_valid, 1'b0);
    chk32("rst2_instr", instr, 32'h0);
    chk1("rst2_misalign", misalign_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_req", imem_req, 1'b1);
    chk32("post_rst_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk1("stale_novalid", instr_valid, 1'b0);
    chk32("stale_instr", instr, 32'h0);
    fetch(32'h0, 0, 2, 32'h0000_2003, 7'h03);
    consume(0, 1'b0, 32'h0, 32'h4);

    chk32("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
